// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: buffers host commands in a small FIFO and issues them one at
// a time to the 8x8 image-processing LCD controller. Between commands cmd sits
// at the NOP code so the controller never re-executes a stale command. The
// write-out command (0) is terminal: it is held until lcd_done, then the
// scheduler halts with finished=1.
module lcd_cmd_sched #(
  parameter int         DEPTH = 8,
  parameter int         CNT_W = 4,
  parameter logic [3:0] NOP   = 4'd15,
  parameter int         GUARD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       host_cmd,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  output logic [CNT_W-1:0] q_count,
  output logic [7:0]       issued_cnt,
  output logic             err,
  output logic             finished
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  logic [2:0]       state;
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       guard_cnt;
  logic             wr_locked;
  logic             accept;
  logic             push;
  logic             pop;
  logic [3:0]       head;

  // Host handshake and FIFO control. A free controller seen in S_WAIT issues
  // straight away, which keeps back-to-back pulses GUARD+2 cycles apart.
  assign host_ready = !reset && (q_count < CNT_W'(DEPTH)) && !wr_locked && !finished;
  assign accept     = host_valid && host_ready;
  assign push       = accept && (host_cmd < 4'd12);
  assign head       = mem[rd_ptr];
  assign pop        = (q_count != '0) && !lcd_busy &&
                      ((state == S_IDLE) || (state == S_WAIT));

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        q_count <= q_count + CNT_W'(1);
      end else if (pop && !push) begin
        q_count <= q_count - CNT_W'(1);
      end
    end
  end

  // Sticky illegal-code flag and the lock that follows an accepted write-out.
  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      wr_locked <= 1'b0;
    end else if (accept) begin
      if (host_cmd >= 4'd12) begin
        err <= 1'b1;
      end
      if (host_cmd == 4'd0) begin
        wr_locked <= 1'b1;
      end
    end
  end

  // Issue sequencer: boot gating, one-cycle pulses, guard/busy spacing and
  // the held write-out command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_BOOT;
      cmd        <= NOP;
      cmd_valid  <= 1'b0;
      issued_cnt <= 8'd0;
      finished   <= 1'b0;
      guard_cnt  <= 2'd0;
    end else begin
      case (state)
        S_BOOT: begin
          if (!lcd_busy) begin
            state <= S_IDLE;
          end
        end
        S_IDLE, S_WAIT: begin
          if (pop) begin
            cmd       <= head;
            cmd_valid <= 1'b1;
            if (issued_cnt != 8'd255) begin
              issued_cnt <= issued_cnt + 8'd1;
            end
            state <= (head == 4'd0) ? S_WRITE : S_PULSE;
          end else if (!lcd_busy) begin
            state <= S_IDLE;
          end
        end
        S_PULSE: begin
          cmd       <= NOP;
          cmd_valid <= 1'b0;
          guard_cnt <= 2'(GUARD);
          state     <= S_GUARD;
        end
        S_GUARD: begin
          guard_cnt <= guard_cnt - 2'd1;
          if (guard_cnt <= 2'd1) begin
            state <= S_WAIT;
          end
        end
        S_WRITE: begin
          if (lcd_done) begin
            cmd       <= NOP;
            cmd_valid <= 1'b0;
            finished  <= 1'b1;
            state     <= S_FIN;
          end else begin
            cmd       <= 4'd0;
            cmd_valid <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_FIN;
        end
        default: begin
          state     <= S_BOOT;
          cmd       <= NOP;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Testbench for lcd_cmd_sched: randomized episodes shaped after the scheduler's
// main scenarios, every output compared each cycle against a queue-based
// reference model of the issue rules.
module tb_lcd_cmd_sched;

  localparam int         DEPTH = 8;
  localparam int         CNT_W = 4;
  localparam logic [3:0] NOP   = 4'd15;
  localparam int         GUARD = 1;

  logic             clk;
  logic             reset;
  logic [3:0]       host_cmd;
  logic             host_valid;
  logic             host_ready;
  logic             lcd_busy;
  logic             lcd_done;
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic [CNT_W-1:0] q_count;
  logic [7:0]       issued_cnt;
  logic             err;
  logic             finished;

  int vectors;
  int miscompares;

  // Reference model: pending commands as a queue, spacing as a cooldown count.
  logic [3:0] m_q[$];
  bit         m_booted;
  bit         m_writing;
  bit         m_fin;
  bit         m_locked;
  bit         m_err;
  int         m_cool;
  int         m_issued;
  int         m_cmd;
  bit         m_valid;

  lcd_cmd_sched #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .NOP(NOP),
    .GUARD(GUARD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host_cmd(host_cmd),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .lcd_busy(lcd_busy),
    .lcd_done(lcd_done),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .q_count(q_count),
    .issued_cnt(issued_cnt),
    .err(err),
    .finished(finished)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_booted  = 0;
    m_writing = 0;
    m_fin     = 0;
    m_locked  = 0;
    m_err     = 0;
    m_cool    = 0;
    m_issued  = 0;
    m_cmd     = NOP;
    m_valid   = 0;
  endtask

  function automatic bit model_ready(input bit rst);
    return !rst && (m_q.size() < DEPTH) && !m_locked && !m_fin;
  endfunction

  // Advance the model across one rising edge using the inputs that edge sees.
  task automatic model_step(input bit rst, input bit hv, input logic [3:0] hc,
                            input bit busy, input bit done);
    bit         rdy;
    int         nxt_cmd;
    bit         nxt_valid;
    logic [3:0] v;
    if (rst) begin
      model_reset();
      return;
    end
    rdy       = model_ready(1'b0);
    nxt_cmd   = NOP;
    nxt_valid = 0;
    if (m_writing) begin
      if (done) begin
        m_writing = 0;
        m_fin     = 1;
      end else begin
        nxt_cmd   = 0;
        nxt_valid = 1;
      end
    end else if (m_fin) begin
      nxt_cmd = NOP;
    end else if (!m_booted) begin
      if (!busy) m_booted = 1;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!busy && m_q.size() > 0) begin
      v         = m_q.pop_front();
      nxt_cmd   = v;
      nxt_valid = 1;
      if (m_issued < 255) m_issued++;
      if (v == 0) m_writing = 1;
      else m_cool = GUARD + 1;
    end
    if (hv && rdy) begin
      if (hc >= 4'd12) begin
        m_err = 1;
      end else begin
        m_q.push_back(hc);
        if (hc == 4'd0) m_locked = 1;
      end
    end
    m_cmd   = nxt_cmd;
    m_valid = nxt_valid;
  endtask

  task automatic check_regs();
    checkOutput("cmd", 32'(cmd), 32'(m_cmd));
    checkOutput("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    checkOutput("q_count", 32'(q_count), 32'(m_q.size()));
    checkOutput("issued_cnt", 32'(issued_cnt), 32'(m_issued));
    checkOutput("err", 32'(err), 32'(m_err));
    checkOutput("finished", 32'(finished), 32'(m_fin));
  endtask

  // One episode: reset for two cycles, then random traffic with the given knobs.
  task automatic applyStimulus(input int n, input int busy_hold, input int busy_pct,
                               input int valid_pct, input int zero_pct, input int bad_pct,
                               input int done_pct, input int rst_pm);
    int r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_regs();
      reset      = (i < 2) || ($urandom_range(0, 999) < rst_pm);
      lcd_busy   = (i < busy_hold) ? 1'b1 : ($urandom_range(0, 99) < busy_pct);
      lcd_done   = ($urandom_range(0, 99) < done_pct);
      host_valid = ($urandom_range(0, 99) < valid_pct);
      r = $urandom_range(0, 99);
      if (r < zero_pct) host_cmd = 4'd0;
      else if (r < zero_pct + bad_pct) host_cmd = 4'(12 + $urandom_range(0, 3));
      else host_cmd = 4'(1 + $urandom_range(0, 10));
      #1;
      checkOutput("host_ready", 32'(host_ready), 32'(model_ready(reset)));
      model_step(reset, host_valid, host_cmd, lcd_busy, lcd_done);
    end
  endtask

  // Episode schedule followed by the summary line.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    host_cmd    = 4'd0;
    host_valid  = 1'b0;
    lcd_busy    = 1'b1;
    lcd_done    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    $display("[TB] boot gating");
    applyStimulus(150, 64, 0, 30, 0, 0, 0, 0);
    $display("[TB] fifo full then drain");
    applyStimulus(200, 40, 0, 100, 0, 0, 0, 0);
    $display("[TB] illegal codes");
    applyStimulus(300, 0, 20, 40, 0, 20, 0, 0);
    $display("[TB] write-out");
    applyStimulus(400, 10, 15, 50, 5, 5, 3, 0);
    $display("[TB] simultaneous push/pop");
    applyStimulus(300, 0, 0, 50, 0, 0, 0, 0);
    $display("[TB] reset mid-write");
    applyStimulus(600, 5, 10, 60, 30, 0, 0, 5);
    $display("[TB] issue counter saturation");
    applyStimulus(1100, 0, 0, 90, 0, 0, 0, 0);
    $display("[TB] mixed traffic");
    for (int e = 0; e < 4; e++) begin
      applyStimulus(250, $urandom_range(0, 20), $urandom_range(0, 50),
                    $urandom_range(10, 90), $urandom_range(0, 4),
                    $urandom_range(0, 10), $urandom_range(0, 10), 2);
    end
    @(negedge clk);
    check_regs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
